// File: rtl/tt_sweep_pkg.sv
// Shared types and default-configuration constants for the truth-table sweeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// N_VEC / CNT_W describe the default build (5 inputs, 2-cycle hold). Modules
// recompute their own widths from their parameters so that non-default
// instances stay consistent.
package tt_sweep_pkg;

    localparam int N_IN_DEF    = 5;
    localparam int N_FN_DEF    = 4;
    localparam int HOLD_DEF    = 2;

    localparam int N_VEC       = 2 ** N_IN_DEF;
    localparam int CNT_W       = (HOLD_DEF > 1) ? $clog2(HOLD_DEF) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a field indexing n items, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tt_mask_bank.sv
// Capture storage: one truth-table mask per function, bit j = value at vector j.
// Latency: write lands on the next clk edge; rd_mask is a combinational read.
// Backpressure: none; clr wins over wr_en, rd_sel beyond N_FN-1 reads 0.
//
// Ports: clk, rst (async, active-high), clr (zero all masks), wr_en/wr_idx/wr_dat
// (write bit wr_idx of every mask k with wr_dat[k]), rd_sel -> rd_mask.
module tt_mask_bank #(
    parameter int N_FN  = tt_sweep_pkg::N_FN_DEF,
    parameter int N_VEC = tt_sweep_pkg::N_VEC,
    parameter int IDX_W = tt_sweep_pkg::width_of(N_VEC),
    parameter int SEL_W = tt_sweep_pkg::width_of(N_FN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [N_FN-1:0]  wr_dat,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [N_VEC-1:0] rd_mask
);

    logic [N_VEC-1:0] mask_q [N_FN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_FN; k++) mask_q[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < N_FN; k++) mask_q[k] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < N_FN; k++) mask_q[k][wr_idx] <= wr_dat[k];
        end
    end

    always_comb begin
        rd_mask = '0;
        if (int'(rd_sel) < N_FN) rd_mask = mask_q[rd_sel];
    end

endmodule

// File: rtl/tt_sweeper.sv
// Truth-table sweeper: drives vectors 0..2^N_IN-1 onto a function block and
// captures one mask per function output, sampling after HOLD_CYCLES of settling.
// Latency: busy for 2^N_IN*HOLD_CYCLES cycles after start, then a 1-cycle done.
// Backpressure: none; start ignored unless IDLE, abort overrides sample and start.
//
// Ports: clk, rst (async, active-high), start, abort, vec_out (bit N_IN-1 = A),
// func_in (outputs under test), busy, done, rd_sel -> rd_mask (combinational).
// Optional self-check, enabled by defining TT_SWEEP_CHECK_EN: exp_mask (packed
// by function index), sticky mismatch, fail_idx / fail_fn of the first failure.
module tt_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int N_IN        = N_IN_DEF,
    parameter int N_FN        = N_FN_DEF,
    parameter int HOLD_CYCLES = HOLD_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic [N_IN-1:0]           vec_out,
    input  logic [N_FN-1:0]           func_in,
    output logic                      busy,
    output logic                      done,
    input  logic [width_of(N_FN)-1:0] rd_sel,
    output logic [2**N_IN-1:0]        rd_mask
`ifdef TT_SWEEP_CHECK_EN
    ,
    input  logic [N_FN*2**N_IN-1:0]   exp_mask,
    output logic                      mismatch,
    output logic [N_IN-1:0]           fail_idx,
    output logic [width_of(N_FN)-1:0] fail_fn
`endif
);

    localparam int VEC_N    = 2 ** N_IN;
    localparam int CNT_BITS = width_of(HOLD_CYCLES);
    localparam int SEL_W    = width_of(N_FN);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0]     IDX_LAST = {N_IN{1'b1}};

    state_t              state_q, state_d;
    logic [N_IN-1:0]     idx_q, idx_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                clr;
    logic                sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        sample  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            SWEEP: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Inputs have been stable for HOLD_CYCLES; take the sample.
                    sample = 1'b1;
                    cnt_d  = '0;
                    // Terminal index is tested explicitly so idx never wraps.
                    if (idx_q == IDX_LAST) state_d = DONE;
                    else                   idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // vec_out is the index register itself, so it holds the last vector after a sweep.
    assign vec_out = idx_q;

    tt_mask_bank #(
        .N_FN  (N_FN),
        .N_VEC (VEC_N),
        .IDX_W (N_IN),
        .SEL_W (SEL_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr_en   (sample),
        .wr_idx  (idx_q),
        .wr_dat  (func_in),
        .rd_sel  (rd_sel),
        .rd_mask (rd_mask)
    );

`ifdef TT_SWEEP_CHECK_EN
    logic [VEC_N-1:0] exp_row [N_FN];
    logic [N_FN-1:0]  diff;
    logic [SEL_W-1:0] first_fn;

    for (genvar g = 0; g < N_FN; g++) begin : g_row
        assign exp_row[g] = exp_mask[g*VEC_N +: VEC_N];
    end

    always_comb begin
        diff = '0;
        for (int k = 0; k < N_FN; k++) diff[k] = func_in[k] ^ exp_row[k][idx_q];
    end

    // Scan high to low so the lowest failing function index is the one kept.
    always_comb begin
        first_fn = '0;
        for (int k = N_FN - 1; k >= 0; k--) begin
            if (diff[k]) first_fn = SEL_W'(k);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
            fail_idx <= '0;
            fail_fn  <= '0;
        end else if (clr) begin
            mismatch <= 1'b0;
            fail_idx <= '0;
            fail_fn  <= '0;
        end else if (sample && !mismatch && (|diff)) begin
            mismatch <= 1'b1;
            fail_idx <= idx_q;
            fail_fn  <= first_fn;
        end
    end
`endif

endmodule

// File: tb/tb_tt_sweeper.sv
// Directed bench for tt_sweeper: table-driven mask reads plus hand-written
// sequences for start-hold, restart, abort, off-edge reset and the self-check.
// Inputs are driven #1 after the rising edge; outputs are sampled there too.
module tb_tt_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  vec_out;
    logic [3:0]  func_in;
    logic        busy;
    logic        done;
    logic [1:0]  rd_sel;
    logic [31:0] rd_mask;
`ifdef TT_SWEEP_CHECK_EN
    logic [127:0] exp_mask;
    logic         mismatch;
    logic [4:0]   fail_idx;
    logic [1:0]   fail_fn;
`endif

    always #5 clk = ~clk;

    tt_sweeper dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .vec_out  (vec_out),
        .func_in  (func_in),
        .busy     (busy),
        .done     (done),
        .rd_sel   (rd_sel),
        .rd_mask  (rd_mask)
`ifdef TT_SWEEP_CHECK_EN
        ,
        .exp_mask (exp_mask),
        .mismatch (mismatch),
        .fail_idx (fail_idx),
        .fail_fn  (fail_fn)
`endif
    );

    // Function block model: vec = {A,B,C,D,E}.
    function automatic logic [3:0] fmodel(input logic [4:0] v);
        logic a, b, c;
        logic [3:0] f;
        a = v[4]; b = v[3]; c = v[2];
        f = 4'b0000;
        f[3] = (a & ~b & c) | (~a & b & ~c) | (a & b & c);
        f[1] = (a | b | c) & (~a | ~b | ~c) & (a | ~b | c);
        return f;
    endfunction

    // Sweep-cycle tracker; func_in is inverted on the first cycle of each vector.
    int sw_cyc   = 0;
    bit prev_busy = 1'b0;
    always @(posedge clk) begin
        #1;
        if (busy) sw_cyc = prev_busy ? sw_cyc + 1 : 0;
        prev_busy = busy;
    end
    assign func_in = fmodel(vec_out) ^ ((busy && (sw_cyc % 2 == 0)) ? 4'hF : 4'h0);

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] exp;
    } rd_vec_t;
    rd_vec_t tbl [4];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply the mask table; keep selects which vector bits are expected captured.
    task automatic check_masks(input string name, input logic [31:0] keep);
        for (int i = 0; i < 4; i++) begin
            rd_sel = tbl[i].sel;
            #1;
            chk($sformatf("%s sel%0d", name, tbl[i].sel), rd_mask, tbl[i].exp & keep);
        end
    endtask

    // One sweep from a start pulse (or held start, released on done).
    task automatic sweep(input bit keep_start, output int bcnt, output int dcnt,
                         output int dat, output int vec_err, output logic [31:0] mask_c1);
        start = 1'b1;
        tick();
        if (!keep_start) start = 1'b0;
        bcnt = 0; dcnt = 0; dat = -1; vec_err = 0; mask_c1 = 'x;
        for (int c = 1; c <= 200; c++) begin
            if (c == 1) mask_c1 = rd_mask;
            if (busy) bcnt++;
            if (c <= 64 && vec_out != 5'((c - 1) / 2)) vec_err++;
            if (c == 65 && vec_out != 5'd31) vec_err++;
            if (done) begin
                dcnt++;
                if (dat < 0) dat = c;
                start = 1'b0;
            end
            if (dat > 0 && c >= dat + 3) break;
            tick();
        end
    endtask

    initial begin
        int bcnt, dcnt, dat, verr, dcount;
        logic [31:0] m1;

        tbl[0] = '{2'd0, 32'h0000_0000};
        tbl[1] = '{2'd1, 32'h0FFF_F0F0};
        tbl[2] = '{2'd2, 32'h0000_0000};
        tbl[3] = '{2'd3, 32'hF0F0_0F00};

        rst = 1'b1; start = 1'b0; abort = 1'b0; rd_sel = 2'd3;
`ifdef TT_SWEEP_CHECK_EN
        exp_mask = {32'hF0F0_0F00, 32'h0, 32'h0FFF_F0F0, 32'h0};
`endif
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset vec_out", 32'(vec_out), 32'd0);
        chk("reset mask3", rd_mask, 32'd0);
        rst = 1'b0;
        tick();

        // Full sweep with a single start pulse.
        rd_sel = 2'd3;
        sweep(1'b0, bcnt, dcnt, dat, verr, m1);
        chk("sweep1 busy cycles", 32'(bcnt), 32'd64);
        chk("sweep1 done count", 32'(dcnt), 32'd1);
        chk("sweep1 done cycle", 32'(dat), 32'd65);
        chk("sweep1 vec_out steps", 32'(verr), 32'd0);
        check_masks("sweep1", 32'hFFFF_FFFF);
`ifdef TT_SWEEP_CHECK_EN
        chk("sweep1 no mismatch", 32'(mismatch), 32'd0);
`endif

        // Start held through the sweep: one sweep, masks cleared then recaptured.
        rd_sel = 2'd3;
        sweep(1'b1, bcnt, dcnt, dat, verr, m1);
        chk("held clear at start", m1, 32'd0);
        chk("held busy cycles", 32'(bcnt), 32'd64);
        chk("held done count", 32'(dcnt), 32'd1);
        chk("held vec_out steps", 32'(verr), 32'd0);
        chk("held no restart", 32'(busy), 32'd0);
        check_masks("sweep2", 32'hFFFF_FFFF);

        // Abort in sweep cycle 20 (first cycle of vector 10).
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        dcount = 0;
        for (int c = 0; c < 70; c++) begin
            if (done) dcount++;
            tick();
        end
        chk("abort no done", 32'(dcount), 32'd0);
        check_masks("abort", 32'h0000_03FF);

        // Abort beats start in IDLE.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort vs start", 32'(busy), 32'd0);

        // Reset asserted off-edge mid-sweep.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst vec_out", 32'(vec_out), 32'd0);
        check_masks("midrst", 32'h0000_0000);
        #3;
        rst = 1'b0;
        tick();

`ifdef TT_SWEEP_CHECK_EN
        exp_mask = {32'hF0F0_0F01, 32'h0, 32'h0FFF_F0F0, 32'h0};
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("chk mismatch", 32'(mismatch), 32'd1);
        chk("chk fail_idx", 32'(fail_idx), 32'd0);
        chk("chk fail_fn", 32'(fail_fn), 32'd3);
        dcount = 0;
        for (int c = 0; c < 100 && dcount == 0; c++) begin
            if (done) begin
                dcount++;
                chk("chk sticky at done", 32'(mismatch), 32'd1);
            end else begin
                tick();
            end
        end
        chk("chk reached done", 32'(dcount), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_sweeper.md
Name: tt_sweeper

Overview:
- Sequential driver/capture stage for the 5-input combinational function blocks in the TP2 exercises.
- Upstream role: drives every input combination onto the function block's inputs, from vector 0 to vector 2^N_IN-1.
- Downstream role: samples the function outputs once they have settled and stores one truth-table mask per function.
- Used on-board and in benches to extract and check minterm sets automatically.

Parameters:
- N_IN, 5, number of function inputs; vec_out width; sweep covers 2^N_IN vectors.
- N_FN, 4, number of function outputs captured.
- HOLD_CYCLES, 2, cycles each vector is held before sampling; legal range >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; accepted only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE without pulsing done.
- vec_out  out  N_IN  current input vector; bit N_IN-1 = A … bit 0 = E.
- func_in  in  N_FN  outputs of the function block under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse after the last vector is sampled.
- rd_sel  in  clog2(N_FN)  selects which captured mask is read.
- rd_mask  out  2^N_IN  captured mask of func_in[rd_sel]; combinational read.

Behaviour:
- Reset (async, rst=1): state=IDLE, vec_out=0, busy=0, done=0, all masks=0, hold counter=0.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - busy=0.
  - On start=1, clear all masks, set idx=0 and cnt=0, go to SWEEP.
- SWEEP:
  - busy=1, vec_out=idx.
  - Each cycle with cnt<HOLD_CYCLES-1: cnt increments.
  - When cnt==HOLD_CYCLES-1: mask[k][idx] <= func_in[k] for all k, and cnt <= 0.
  - After that sample: if idx==2^N_IN-1, go to DONE; otherwise idx increments.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - vec_out holds the last vector.
- Timing: with start sampled at edge e0, busy is high for 2^N_IN*HOLD_CYCLES cycles. Defaults: 64 cycles, done in the 65th cycle after e0.
- Masks hold their value from DONE until the next accepted start.
- start while busy or in DONE: ignored, no restart.
- abort: priority over sample and start in the same cycle. Goes to IDLE, busy=0, no done pulse; partially captured masks are retained.
- Reset mid-sweep: immediate return to reset values.
- idx wrap: never wraps inside a sweep; terminal index is detected explicitly.
- rd_mask bit j = value of the selected function at vector j.
- rd_sel >= N_FN returns 0.

Optional Feature:
- Macro: TT_SWEEP_CHECK_EN.
- When defined, adds these ports:
  - exp_mask  in  N_FN*2^N_IN  expected masks, packed by function index.
  - mismatch  out  1  sticky flag.
  - fail_idx  out  N_IN  first failing vector.
  - fail_fn  out  clog2(N_FN)  function index of the first failure.
- mismatch sets at the first sample whose func_in differs from the expected bit. Simultaneous failures report the lowest function index.
- mismatch, fail_idx and fail_fn are cleared on accepted start and on reset; abort does not clear them.
- When undefined, none of these ports or their logic exist.

Decomposition:
- Package tt_sweep_pkg holds:
  - state enum {IDLE, SWEEP, DONE}.
  - localparams N_VEC = 2**N_IN and CNT_W = clog2(HOLD_CYCLES).
- One natural sub-module: tt_mask_bank, i.e. N_FN x N_VEC capture registers with clear, a per-index write and the rd_sel mux.

Test Plan:
- Bench model: func_in[3] = A&~B&C | ~A&B&~C | A&B&C; func_in[1] = (A|B|C)&(~A|~B|~C)&(A|~B|C); func_in[2] = func_in[0] = 0.
- Full sweep, HOLD_CYCLES=2: start pulse → busy high 64 cycles, done pulse in cycle 65; rd_sel=3 gives 0xF0F00F00, rd_sel=1 gives 0x0FFFF0F0, rd_sel=0 gives 0x00000000.
- Vector timing: vec_out steps 0,0,1,1,…,31,31 on consecutive cycles. A func_in glitch on the first cycle of each vector must not appear in any mask.
- start held high through the whole sweep → exactly one sweep and one done pulse; second start after DONE → masks cleared, then recaptured identically.
- abort in cycle 20 of the sweep → busy=0 next cycle, no done pulse; rd_mask bits 0-9 captured, bits 10-31 = 0.
- rst asserted mid-sweep (asynchronously, off-edge) → busy, done and vec_out go to 0 immediately; all masks = 0.
- TT_SWEEP_CHECK_EN: exp_mask for fn3 = 0xF0F00F01 → mismatch=1, fail_idx=0, fail_fn=3 after the first sample; flag stays set through DONE.
